ahb_apb_bridge: RTL and testbench

//  AHB-Lite slave that converts single AHB transfers into APB3 transfers to NUM_PSLV peripherals.

---
 rtl/ahb_apb_bridge.sv | 140 ++++++++++++++
 tb/tb_ahb_apb_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave that bridges single AHB transfers onto an APB3 bus with NUM_PSLV peripherals.
// Illegal peripheral index, illegal size or PSLVERR produce a two-cycle AHB ERROR response.
module ahb_apb_bridge #(
    parameter int unsigned NUM_PSLV = 4,
    parameter int unsigned PADDR_W  = 12,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                HSEL,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [31:0]         HWDATA,
    input  logic                HREADY,
    output logic                HREADYOUT,
    output logic [1:0]          HRESP,
    output logic [31:0]         HRDATA,
    output logic [PADDR_W-1:0]  PADDR,
    output logic [NUM_PSLV-1:0] PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [31:0]         PWDATA,
    input  logic [31:0]         PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [IDX_W:0] NUM_PSLV_L = (IDX_W + 1)'(NUM_PSLV);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] haddr_idx;
    logic             accept;
    logic             legal;
    logic             unused_haddr;

    assign haddr_idx    = HADDR[PADDR_W+IDX_W-1:PADDR_W];
    assign unused_haddr = &{1'b0, HADDR[31:PADDR_W+IDX_W], HTRANS[0]};

    always_comb begin
        accept = (state inside {S_IDLE, S_DONE, S_ERR2}) & HSEL & HTRANS[1] & HREADY;
        legal  = ({1'b0, haddr_idx} < NUM_PSLV_L) && (HSIZE <= 3'd2);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        HREADYOUT = 1'b1;
        HRESP     = 2'b00;
        PENABLE   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (state == S_ERR2) begin
                    HRESP = 2'b01;
                end
                if (accept) begin
                    state_nxt = legal ? S_LATCH : S_ERR1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_LATCH: begin
                HREADYOUT = 1'b0;
                state_nxt = S_SETUP;
            end
            S_SETUP: begin
                HREADYOUT = 1'b0;
                state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                HREADYOUT = 1'b0;
                PENABLE   = 1'b1;
                if (PREADY) begin
                    state_nxt = PSLVERR ? S_ERR1 : S_DONE;
                end
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 2'b01;
                state_nxt = S_ERR2;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // PSEL is decoded from the registered index, so it is one-hot or zero by construction
    always_comb begin
        PSEL = '0;
        if (state == S_SETUP || state == S_ACCESS) begin
            for (int unsigned i = 0; i < NUM_PSLV; i++) begin
                PSEL[i] = (idx_q == IDX_W'(i));
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            idx_q  <= '0;
            PWDATA <= '0;
            HRDATA <= '0;
        end else begin
            if (accept) begin
                PADDR  <= HADDR[PADDR_W-1:0];
                PWRITE <= HWRITE;
                idx_q  <= haddr_idx;
            end
            if (state == S_LATCH && PWRITE) begin
                PWDATA <= HWDATA;
            end
            if (state == S_ACCESS && PREADY && !PSLVERR && !PWRITE) begin
                HRDATA <= PRDATA;
            end
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Scoreboard bench for ahb_apb_bridge: AHB master driver, APB responder and response monitor.
module tb_ahb_apb_bridge;

    localparam int unsigned NUM_PSLV = 4;
    localparam int unsigned PADDR_W  = 12;
    localparam int unsigned IDX_W    = 4;

    logic                HCLK = 1'b0;
    logic                HRESET;
    logic                HSEL;
    logic [31:0]         HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic [31:0]         HWDATA;
    logic                HREADY;
    logic                HREADYOUT;
    logic [1:0]          HRESP;
    logic [31:0]         HRDATA;
    logic [PADDR_W-1:0]  PADDR;
    logic [NUM_PSLV-1:0] PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [31:0]         PWDATA;
    logic [31:0]         PRDATA;
    logic                PREADY;
    logic                PSLVERR;

    assign HREADY = HREADYOUT;

    ahb_apb_bridge #(
        .NUM_PSLV(NUM_PSLV),
        .PADDR_W (PADDR_W),
        .IDX_W   (IDX_W)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP),
        .HRDATA   (HRDATA),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [1:0]          resp;
        logic                is_read;
        logic [31:0]         rdata;
        logic [NUM_PSLV-1:0] psel;
        logic [PADDR_W-1:0]  paddr;
        logic [31:0]         pwdata;
        int                  lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic void push(input logic [1:0] resp, input logic is_read, input logic [31:0] rdata,
                                 input logic [NUM_PSLV-1:0] psel, input logic [PADDR_W-1:0] paddr,
                                 input logic [31:0] pwdata, input int lat);
        exp_t e;
        e.resp    = resp;
        e.is_read = is_read;
        e.rdata   = rdata;
        e.psel    = psel;
        e.paddr   = paddr;
        e.pwdata  = pwdata;
        e.lat     = lat;
        sb.push_back(e);
    endfunction

    // APB responder: PREADY stays low for wait_cfg ACCESS cycles
    int   wait_cfg = 0;
    int   wait_cnt = 0;
    logic err_cfg  = 1'b0;

    always @(posedge HCLK) begin
        if (PSEL != '0 && !PENABLE) begin
            wait_cnt <= wait_cfg;
        end else if (PENABLE && wait_cnt != 0) begin
            wait_cnt <= wait_cnt - 1;
        end
    end

    assign PREADY  = (wait_cnt == 0);
    assign PSLVERR = err_cfg;

    // Monitor: tracks AHB data phases and APB activity, pops the scoreboard on completion
    int                  cyc     = 0;
    int                  t0      = 0;
    bit                  in_dp   = 1'b0;
    logic [NUM_PSLV-1:0] psel_or = '0;
    logic [PADDR_W-1:0]  cap_paddr  = '0;
    logic [31:0]         cap_pwdata = '0;
    logic [2:0]          prev_rr    = 3'b100;

    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            cyc++;
            if (HRESET) begin
                in_dp   = 1'b0;
                psel_or = '0;
            end else begin
                psel_or |= PSEL;
                if (PENABLE && PREADY) begin
                    cap_paddr  = PADDR;
                    cap_pwdata = PWDATA;
                end
                if (in_dp && HREADYOUT) begin
                    in_dp = 1'b0;
                    check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check_eq("hresp", 32'(HRESP), 32'(e.resp));
                        check_eq("latency", 32'(cyc - t0), 32'(e.lat));
                        check_eq("psel", 32'(psel_or), 32'(e.psel));
                        if (e.psel != '0) begin
                            check_eq("paddr", 32'(cap_paddr), 32'(e.paddr));
                            if (!e.is_read) begin
                                check_eq("pwdata", cap_pwdata, e.pwdata);
                            end
                        end
                        if (e.is_read && e.resp == 2'b00) begin
                            check_eq("hrdata", HRDATA, e.rdata);
                        end
                        if (e.resp == 2'b01) begin
                            check_eq("err1_cycle", 32'(prev_rr), 32'h1);
                        end
                    end
                end
                if (HSEL && HTRANS[1] && HREADYOUT) begin
                    in_dp   = 1'b1;
                    t0      = cyc;
                    psel_or = '0;
                end
            end
            prev_rr = {HREADYOUT, HRESP};
        end
    end

    task automatic step_ready();
        bit got = 1'b0;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge HCLK);
            if (HREADYOUT) begin
                got = 1'b1;
            end
        end
        check_eq("hready_wait", 32'(got), 32'd1);
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] s);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = a;
        HWRITE = w;
        HSIZE  = s;
    endtask

    task automatic idle_bus();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_hreadyout"}, 32'(HREADYOUT), 32'd1);
        check_eq({tag, "_hresp"}, 32'(HRESP), 32'd0);
        check_eq({tag, "_psel"}, 32'(PSEL), 32'd0);
        check_eq({tag, "_penable"}, 32'(PENABLE), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        HRESET = 1'b1;
        HSEL   = 1'b0;
        HADDR  = '0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'd2;
        HWDATA = '0;
        PRDATA = '0;
        repeat (3) @(posedge HCLK);
        #1;
        check_idle_outputs("reset");
        check_eq("reset_hrdata", HRDATA, 32'd0);
        check_eq("reset_paddr", 32'(PADDR), 32'd0);
        check_eq("reset_pwdata", PWDATA, 32'd0);
        check_eq("reset_pwrite", 32'(PWRITE), 32'd0);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        // single write, zero-wait peripheral
        wait_cfg = 0;
        addr_ph(32'h4000_1008, 1'b1, 3'd2);
        push(2'b00, 1'b0, 32'h0, 4'b0010, 12'h008, 32'hDEAD_BEEF, 4);
        step_ready();
        idle_bus();
        HWDATA = 32'hDEAD_BEEF;
        step_ready();
        HWDATA = 32'h0BAD_F00D;

        // read with three wait states
        wait_cfg = 3;
        PRDATA   = 32'h1234_5678;
        addr_ph(32'h4000_3010, 1'b0, 3'd2);
        push(2'b00, 1'b1, 32'h1234_5678, 4'b1000, 12'h010, 32'h0, 7);
        step_ready();
        idle_bus();
        step_ready();

        // illegal index, then illegal size
        wait_cfg = 0;
        addr_ph(32'h4000_5000, 1'b0, 3'd2);
        push(2'b01, 1'b1, 32'h0, 4'b0000, 12'h000, 32'h0, 2);
        step_ready();
        idle_bus();
        step_ready();
        addr_ph(32'h4000_0000, 1'b1, 3'd3);
        push(2'b01, 1'b0, 32'h0, 4'b0000, 12'h000, 32'h0, 2);
        step_ready();
        idle_bus();
        step_ready();

        // idle bus, BUSY and deselected NONSEQ give OKAY zero-wait responses
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            check_idle_outputs("idle");
        end
        HSEL   = 1'b1;
        HTRANS = 2'b01;
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            check_idle_outputs("busy");
        end
        HSEL   = 1'b0;
        HTRANS = 2'b10;
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            check_idle_outputs("nosel");
        end
        @(posedge HCLK);
        #1;
        idle_bus();

        // PSLVERR write; next NONSEQ accepted in ERR2
        err_cfg = 1'b1;
        addr_ph(32'h4000_2004, 1'b1, 3'd2);
        push(2'b01, 1'b0, 32'h0, 4'b0100, 12'h004, 32'h5555_AAAA, 5);
        step_ready();
        HWDATA = 32'h5555_AAAA;
        addr_ph(32'h4000_0020, 1'b0, 3'd2);
        push(2'b00, 1'b1, 32'hA5A5_5A5A, 4'b0001, 12'h020, 32'h0, 4);
        step_ready();
        err_cfg = 1'b0;
        PRDATA  = 32'hA5A5_5A5A;
        idle_bus();
        step_ready();

        // back-to-back writes, second issued during the first's DONE cycle
        wait_cfg = 1;
        addr_ph(32'h4000_0000, 1'b1, 3'd2);
        push(2'b00, 1'b0, 32'h0, 4'b0001, 12'h000, 32'h1111_1111, 5);
        step_ready();
        HWDATA = 32'h1111_1111;
        addr_ph(32'h4000_1FFC, 1'b1, 3'd1);
        push(2'b00, 1'b0, 32'h0, 4'b0010, 12'hFFC, 32'h2222_2222, 5);
        step_ready();
        HWDATA = 32'h2222_2222;
        idle_bus();
        step_ready();

        // reset during ACCESS drops the transfer
        wait_cfg = 6;
        PRDATA   = 32'h7777_7777;
        addr_ph(32'h4000_1100, 1'b0, 3'd2);
        step_ready();
        idle_bus();
        seen = 1'b0;
        for (int n = 0; n < 16 && !seen; n++) begin
            @(negedge HCLK);
            seen = PENABLE;
        end
        check_eq("reach_access", 32'(seen), 32'd1);
        @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        check_idle_outputs("midrst");
        check_eq("midrst_hrdata", HRDATA, 32'd0);
        check_eq("midrst_paddr", 32'(PADDR), 32'd0);
        check_eq("midrst_pwdata", PWDATA, 32'd0);
        check_eq("midrst_pwrite", 32'(PWRITE), 32'd0);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        wait_cfg = 1;
        PRDATA   = 32'hCAFE_F00D;
        addr_ph(32'h4000_2040, 1'b0, 3'd2);
        push(2'b00, 1'b1, 32'hCAFE_F00D, 4'b0100, 12'h040, 32'h0, 5);
        step_ready();
        idle_bus();
        step_ready();

        repeat (3) @(posedge HCLK);
        #1;
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
